izigzag_reorder: RTL and testbench

- Inverse of the encoder's zigzag stage, for the decoder path (entropy decode → dequant → IDCT).
- Accepts 64 coefficients per 8x8 block in JPEG zigzag scan order. Emits the same coefficients in raster order (row-major, index = 8*row + col).
- Ping-pong double buffer: one block is written while the previous block is read, giving full throughput.

---
 rtl/izigzag_reorder.sv | 206 ++++++++++++++++++++
 tb/tb_izigzag_reorder.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izigzag_reorder.sv
// Inverse zigzag reorder for the decoder path.
// Takes 64 coefficients per 8x8 block in JPEG zigzag scan order and emits
// them in raster order (index = 8*row + col). Two 64-entry banks form a
// ping-pong buffer, so one block can be written while the previous one is
// read out at one coefficient per cycle.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   in_valid/in_ready  write handshake; in_ready is low only when the bank
//                      being written still holds an unread block
//   in_data            coefficient in zigzag order
//   in_sob             start-of-block marker, expected with the first word
//   out_valid/out_ready read handshake, registered output stage
//   out_data           coefficient in raster order
//   out_idx            raster index of out_data
//   out_sob            high with out_idx == 0
//   err_sob            one-cycle pulse when in_sob arrives mid-block
module izigzag_reorder #(
    parameter int unsigned DWIDTH = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_sob,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [5:0]        out_idx,
    output logic              out_sob,
    output logic              err_sob
);

    localparam int unsigned IDX_W  = 6;
    localparam int unsigned ADDR_W = IDX_W + 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(63);

    // Zigzag scan position -> raster index (standard JPEG table).
    function automatic logic [IDX_W-1:0] zz2r(input logic [IDX_W-1:0] k);
        logic [IDX_W-1:0] r;
        r = '0;
        case (k)
            6'd0:  r = 6'd0;
            6'd1:  r = 6'd1;
            6'd2:  r = 6'd8;
            6'd3:  r = 6'd16;
            6'd4:  r = 6'd9;
            6'd5:  r = 6'd2;
            6'd6:  r = 6'd3;
            6'd7:  r = 6'd10;
            6'd8:  r = 6'd17;
            6'd9:  r = 6'd24;
            6'd10: r = 6'd32;
            6'd11: r = 6'd25;
            6'd12: r = 6'd18;
            6'd13: r = 6'd11;
            6'd14: r = 6'd4;
            6'd15: r = 6'd5;
            6'd16: r = 6'd12;
            6'd17: r = 6'd19;
            6'd18: r = 6'd26;
            6'd19: r = 6'd33;
            6'd20: r = 6'd40;
            6'd21: r = 6'd48;
            6'd22: r = 6'd41;
            6'd23: r = 6'd34;
            6'd24: r = 6'd27;
            6'd25: r = 6'd20;
            6'd26: r = 6'd13;
            6'd27: r = 6'd6;
            6'd28: r = 6'd7;
            6'd29: r = 6'd14;
            6'd30: r = 6'd21;
            6'd31: r = 6'd28;
            6'd32: r = 6'd35;
            6'd33: r = 6'd42;
            6'd34: r = 6'd49;
            6'd35: r = 6'd56;
            6'd36: r = 6'd57;
            6'd37: r = 6'd50;
            6'd38: r = 6'd43;
            6'd39: r = 6'd36;
            6'd40: r = 6'd29;
            6'd41: r = 6'd22;
            6'd42: r = 6'd15;
            6'd43: r = 6'd23;
            6'd44: r = 6'd30;
            6'd45: r = 6'd37;
            6'd46: r = 6'd44;
            6'd47: r = 6'd51;
            6'd48: r = 6'd58;
            6'd49: r = 6'd59;
            6'd50: r = 6'd52;
            6'd51: r = 6'd45;
            6'd52: r = 6'd38;
            6'd53: r = 6'd31;
            6'd54: r = 6'd39;
            6'd55: r = 6'd46;
            6'd56: r = 6'd53;
            6'd57: r = 6'd60;
            6'd58: r = 6'd61;
            6'd59: r = 6'd54;
            6'd60: r = 6'd47;
            6'd61: r = 6'd55;
            6'd62: r = 6'd62;
            6'd63: r = 6'd63;
            default: r = '0;
        endcase
        return r;
    endfunction

    // Both banks share one array; the top address bit selects the bank.
    logic [DWIDTH-1:0] mem [DEPTH];

    logic [1:0]       full;
    logic             wr_bank;
    logic             rd_bank;
    logic [IDX_W-1:0] wr_cnt;
    logic [IDX_W-1:0] rd_cnt;

    logic             wr_acc_c;
    logic             sob_err_c;
    logic [IDX_W-1:0] wr_idx_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [ADDR_W-1:0] rd_addr_c;
    logic             wr_done_c;
    logic             rd_load_c;
    logic             rd_done_c;
    logic [1:0]       full_nxt_c;
    logic             wr_bank_nxt_c;

    // Write/read decode and next-state of the shared bank flags.
    always_comb begin
        wr_acc_c  = in_valid && in_ready;
        sob_err_c = wr_acc_c && in_sob && (wr_cnt != '0);
        // A misplaced in_sob restarts the block: this word becomes index 0.
        wr_idx_c  = sob_err_c ? '0 : wr_cnt;
        wr_addr_c = {wr_bank, zz2r(wr_idx_c)};
        wr_done_c = wr_acc_c && (wr_idx_c == LAST_IDX);

        rd_load_c = full[rd_bank] && (!out_valid || out_ready);
        rd_done_c = rd_load_c && (rd_cnt == LAST_IDX);
        rd_addr_c = {rd_bank, rd_cnt};

        // Completing write and completing read always hit different banks.
        full_nxt_c = full;
        if (wr_done_c) begin
            full_nxt_c[wr_bank] = 1'b1;
        end
        if (rd_done_c) begin
            full_nxt_c[rd_bank] = 1'b0;
        end
        wr_bank_nxt_c = wr_bank ^ wr_done_c;
    end

    // Coefficient storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc_c && !rst) begin
            mem[wr_addr_c] <= in_data;
        end
    end

    // Control state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            full      <= 2'b00;
            wr_bank   <= 1'b0;
            rd_bank   <= 1'b0;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_sob   <= 1'b0;
            err_sob   <= 1'b0;
        end else begin
            full    <= full_nxt_c;
            wr_bank <= wr_bank_nxt_c;
            // Derived from next-state flags so it equals !full[wr_bank] of
            // the coming cycle; a freed bank is writable one cycle later.
            in_ready <= !full_nxt_c[wr_bank_nxt_c];
            err_sob  <= sob_err_c;

            if (wr_acc_c) begin
                wr_cnt <= IDX_W'(wr_idx_c + IDX_W'(1));
            end

            if (rd_load_c) begin
                out_valid <= 1'b1;
                out_data  <= mem[rd_addr_c];
                out_idx   <= rd_cnt;
                out_sob   <= (rd_cnt == '0);
                rd_cnt    <= IDX_W'(rd_cnt + IDX_W'(1));
                if (rd_done_c) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_izigzag_reorder.sv
// Self-checking bench for izigzag_reorder: a write-side monitor feeds an
// independent zigzag model that queues raster-order expectations; the
// read-side monitor pops and compares them.
module tb_izigzag_reorder;

    localparam int unsigned DW = 12;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sob;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [5:0]    out_idx;
    logic          out_sob;
    logic          err_sob;

    izigzag_reorder #(.DWIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sob    (in_sob),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_sob   (out_sob),
        .err_sob   (err_sob)
    );

    typedef struct {
        logic [DW-1:0] data;
        logic [5:0]    idx;
    } exp_t;

    exp_t          q[$];
    int            zz2r [64];
    logic [DW-1:0] blk  [64];
    int            m_cnt;

    int n_vec = 0;
    int n_err = 0;

    int cyc = 0;
    int last_acc_cyc = 0;
    int first_ov_cyc = 0;
    bit ov_seen = 0;
    int n_out = 0;
    int bubbles = 0;
    int stalls = 0;
    int acc_win = 0;
    int err_seen = 0;

    bit            hold_pending = 0;
    logic [DW-1:0] hold_data;
    logic [5:0]    hold_idx;
    logic          hold_sob;

    bit   ready_mode = 0;
    logic rdy_val = 1'b0;
    bit   rnd_gaps = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Independent zigzag model: walk anti-diagonals, alternating direction.
    initial begin
        int k;
        k = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz2r[k] = 8 * r + (s - r);
                    k++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz2r[k] = 8 * r + (s - r);
                    k++;
                end
            end
        end
    end

    // Downstream ready: constant or 50% random.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_mode ? 1'($urandom_range(0, 1)) : rdy_val;
        end
    end

    // Monitor: inputs and outputs are both stable at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
            m_cnt = 0;
            hold_pending = 0;
        end else begin
            if (in_valid && !in_ready) stalls++;
            if (in_valid && in_ready) begin
                acc_win++;
                if (in_sob && m_cnt != 0) m_cnt = 0;
                blk[zz2r[m_cnt]] = in_data;
                m_cnt++;
                if (m_cnt == 64) begin
                    for (int r = 0; r < 64; r++) q.push_back('{blk[r], 6'(r)});
                    m_cnt = 0;
                    last_acc_cyc = cyc;
                end
            end
            if (hold_pending) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_data));
                check("hold_idx", 32'(out_idx), 32'(hold_idx));
                check("hold_sob", 32'(out_sob), 32'(hold_sob));
            end
            hold_pending = out_valid && !out_ready;
            hold_data = out_data;
            hold_idx = out_idx;
            hold_sob = out_sob;
            if (out_valid && !ov_seen) begin
                ov_seen = 1;
                first_ov_cyc = cyc;
            end
            if (n_out > 0 && n_out < 256 && !out_valid) bubbles++;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    check("unexpected_out", 32'(out_idx), 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out_data", 32'(out_data), 32'(e.data));
                    check("out_idx", 32'(out_idx), 32'(e.idx));
                    check("out_sob", 32'(out_sob), 32'(e.idx == 6'd0));
                end
            end
            if (err_sob) err_seen++;
        end
    end

    task automatic send_word(input logic [DW-1:0] d, input logic s);
        if (rnd_gaps) begin
            for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data = d;
        in_sob = s;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t >= 2000) begin
                check("in_timeout", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sob = 1'b0;
    endtask

    task automatic send_block(input int base, input bit rnd_data);
        for (int k = 0; k < 64; k++) begin
            send_word(rnd_data ? DW'($urandom) : DW'(base + k), k == 0);
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q.size() != 0 || out_valid) && t < 5000) begin
            @(negedge clk);
            t++;
        end
        check("drain_left", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_data = '0;
        in_sob = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_sob", 32'(out_sob), 32'd0);
        check("rst_err_sob", 32'(err_sob), 32'd0);
        @(posedge clk);
        #1;

        // Single block, data = zigzag position.
        rdy_val = 1'b1;
        ov_seen = 0;
        send_block(0, 0);
        drain();
        check("latency", 32'(first_ov_cyc - last_acc_cyc), 32'd2);

        // Four back-to-back blocks: no stalls, no bubbles.
        n_out = 0;
        bubbles = 0;
        stalls = 0;
        for (int b = 0; b < 4; b++) send_block(64 * b, 0);
        drain();
        check("b2b_outputs", 32'(n_out), 32'd256);
        check("b2b_bubbles", 32'(bubbles), 32'd0);
        check("b2b_stalls", 32'(stalls), 32'd0);

        // Full backpressure: exactly two banks' worth accepted.
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        acc_win = 0;
        fork
            for (int b = 0; b < 3; b++) send_block(1000 + 64 * b, 0);
            begin
                repeat (200) @(negedge clk);
                check("bp_accepted", 32'(acc_win), 32'd128);
                check("bp_in_ready", 32'(in_ready), 32'd0);
                check("bp_out_valid", 32'(out_valid), 32'd1);
                check("bp_head_idx", 32'(out_idx), 32'd0);
                check("bp_head_data", 32'(out_data), 32'd1000);
                rdy_val = 1'b1;
            end
        join
        drain();

        // Random handshakes, 20 blocks of random data.
        ready_mode = 1;
        rnd_gaps = 1;
        for (int b = 0; b < 20; b++) send_block(0, 1);
        rnd_gaps = 0;
        ready_mode = 0;
        drain();

        // Misplaced start-of-block after 10 words.
        err_seen = 0;
        for (int k = 0; k < 10; k++) send_word(DW'(3000 + k), k == 0);
        send_block(2000, 0);
        drain();
        check("sob_err_pulses", 32'(err_seen), 32'd1);

        // Reset mid-write with one full bank pending.
        rdy_val = 1'b0;
        @(posedge clk);
        #1;
        send_block(500, 0);
        for (int k = 0; k < 30; k++) send_word(DW'(600 + k), k == 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rdy_val = 1'b1;
        n_out = 0;
        send_block(700, 0);
        drain();
        check("post_rst_outputs", 32'(n_out), 32'd64);
        check("final_queue", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
